// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT pipeline stages.
//   clog2()   : ceiling log2 of a positive integer, usable in localparams
//   bitrev()  : reverse the low nbits bits of an index (upper bits return 0)
//   fftState_t: two-state enum used by the streaming stages (IDLE / STREAM)
// ---------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fftState_t;

    // Smallest r such that (1 << r) >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Shift bits out of the bottom of idx and into the bottom of the result.
    // After nbits steps the low nbits of the result are the mirrored index.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] src;
        logic [31:0] result;
        src    = idx;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                result = {result[30:0], src[0]};
                src    = src >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// ---------------------------------------------------------------------------
// fft_reorder_ram
// Simple dual-port RAM backing the reorder ping-pong buffer. One write port,
// one read port with a registered output. The array is not reset; every
// location of a bank is rewritten before that bank is ever read.
//   clock    : rising-edge clock for both ports
//   i_wrEn   : write strobe
//   i_wrAddr : write address {bank, index}
//   i_wrData : write word {real, imaginary}
//   i_rdEn   : read strobe; o_rdData updates one edge later
//   i_rdAddr : read address {bank, index}
//   o_rdData : registered read word
// ---------------------------------------------------------------------------
module fft_reorder_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdData;

    // Write port: the write side and the read side always sit in different
    // banks, so no read-during-write forwarding is needed.
    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read port: registered output, holds its last word when not reading.
    always_ff @(posedge clock) begin
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Takes the bit-reversed output stream of the 64-point SDF FFT and re-emits
// every frame in natural bin order (0..N-1) through a two-bank ping-pong
// buffer. Writes land at bitrev(write count); the completed bank is read
// out sequentially. Bin 0 leaves two edges after the edge that writes the
// last sample of its frame, and back-to-back frames stream with no bubble.
//
// Ports:
//   clock               : rising-edge clock
//   reset               : asynchronous, active-high, clears all state
//   data_input_en       : input sample valid
//   data_input_real     : input real part (bit-reversed order)
//   data_input_complex  : input imaginary part (bit-reversed order)
//   data_output_en      : output sample valid
//   data_output_real    : output real part (natural order)
//   data_output_complex : output imaginary part (natural order)
//   data_output_sof     : high with bin 0 of each frame (only when the
//                         FFT_REORDER_SOF_EN macro is defined)
//
// Build option: define FFT_REORDER_SOF_EN to add the data_output_sof port.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_input_en,
    input  logic [WIDTH-1:0] data_input_real,
    input  logic [WIDTH-1:0] data_input_complex,
    output logic             data_output_en,
`ifdef FFT_REORDER_SOF_EN
    output logic             data_output_sof,
`endif
    output logic [WIDTH-1:0] data_output_real,
    output logic [WIDTH-1:0] data_output_complex
);

    localparam int               LOG2N    = clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);

    logic [LOG2N-1:0]   r_wrCnt;
    logic               r_wrBank;
    logic [LOG2N-1:0]   r_rdCnt;
    logic               r_rdBank;
    fftState_t          r_state;
    fftState_t          w_nextState;
    logic               w_frameDone;
    logic               w_lastRead;
    logic               w_readEn;
    logic [LOG2N-1:0]   w_wrIdx;
    logic [2*WIDTH-1:0] w_ramData;
    logic               r_rdValid;
    logic               r_outEn;
    logic [WIDTH-1:0]   r_outReal;
    logic [WIDTH-1:0]   r_outImag;

    // frame_done is combinational so the read FSM can start on the same edge
    // that writes the last sample; that is what gives the two-edge latency.
    assign w_frameDone = data_input_en && (r_wrCnt == LAST_IDX);
    assign w_lastRead  = (r_rdCnt == LAST_IDX);
    assign w_wrIdx     = LOG2N'(bitrev({{(32-LOG2N){1'b0}}, r_wrCnt}, LOG2N));

    // Write side: count accepted samples and flip banks at each frame wrap.
    // The counter wraps naturally because N is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrCnt  <= '0;
            r_wrBank <= 1'b0;
        end else if (data_input_en) begin
            r_wrCnt <= r_wrCnt + ONE_IDX;
            if (w_frameDone) begin
                r_wrBank <= ~r_wrBank;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Read FSM next state: a completed frame always starts (or restarts) a
    // stream; a stream that reaches its last bin with nothing new goes idle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_frameDone) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (w_frameDone) begin
                    w_nextState = STREAM;
                end else if (w_lastRead) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Read FSM outputs: one RAM read per cycle while streaming.
    always_comb begin
        w_readEn = (r_state == STREAM);
    end

    // Read counter and bank. A new frame always wins: if one completes while
    // an older frame is still streaming, the old one is cut short.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdCnt  <= '0;
            r_rdBank <= 1'b0;
        end else if (w_frameDone) begin
            r_rdCnt  <= '0;
            r_rdBank <= r_wrBank;
        end else if (w_readEn) begin
            r_rdCnt <= r_rdCnt + ONE_IDX;
        end
    end

    fft_reorder_ram #(
        .ADDR_W (LOG2N + 1),
        .DATA_W (2 * WIDTH)
    ) u_ram (
        .clock    (clock),
        .i_wrEn   (data_input_en),
        .i_wrAddr ({r_wrBank, w_wrIdx}),
        .i_wrData ({data_input_real, data_input_complex}),
        .i_rdEn   (w_readEn),
        .i_rdAddr ({r_rdBank, r_rdCnt}),
        .o_rdData (w_ramData)
    );

    // Output stage: r_rdValid tracks the RAM read latency, then the word is
    // captured into the output register. Data holds while no sample is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdValid <= 1'b0;
            r_outEn   <= 1'b0;
            r_outReal <= '0;
            r_outImag <= '0;
        end else begin
            r_rdValid <= w_readEn;
            r_outEn   <= r_rdValid;
            if (r_rdValid) begin
                r_outReal <= w_ramData[2*WIDTH-1:WIDTH];
                r_outImag <= w_ramData[WIDTH-1:0];
            end
        end
    end

    assign data_output_en      = r_outEn;
    assign data_output_real    = r_outReal;
    assign data_output_complex = r_outImag;

`ifdef FFT_REORDER_SOF_EN
    logic r_rdSof;
    logic r_outSof;

    // Start-of-frame marker follows the same two-stage path as the data so it
    // lines up with bin 0 at the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdSof  <= 1'b0;
            r_outSof <= 1'b0;
        end else begin
            r_rdSof  <= w_readEn && (r_rdCnt == '0);
            r_outSof <= r_rdSof;
        end
    end

    assign data_output_sof = r_outSof;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Directed bench for the bit-reversal reorder stage at N=64, WIDTH=16.
// Input sample k of a frame carries re = bitrev6(k) + offset, im = ~re, so
// natural-order output bin j must carry re = j + offset, im = ~(j + offset).
// Define FFT_REORDER_SOF_EN to also exercise the start-of-frame output.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

    localparam int N     = 64;
    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             data_input_en;
    logic [WIDTH-1:0] data_input_real;
    logic [WIDTH-1:0] data_input_complex;
    logic             data_output_en;
    logic [WIDTH-1:0] data_output_real;
    logic [WIDTH-1:0] data_output_complex;
`ifdef FFT_REORDER_SOF_EN
    logic             data_output_sof;
    int               straySof = 0;
`endif

    typedef struct {
        int         cyc;
        logic [15:0] re;
        logic [15:0] im;
        logic        sof;
    } outRec_t;

    outRec_t outQ[$];
    outRec_t colRec;
    int      cycleCnt    = 0;
    int      lastWrite   = 0;
    int      testsRun    = 0;
    int      testsFailed = 0;

    fft_bitrev_reorder #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .data_input_en       (data_input_en),
        .data_input_real     (data_input_real),
        .data_input_complex  (data_input_complex),
        .data_output_en      (data_output_en),
`ifdef FFT_REORDER_SOF_EN
        .data_output_sof     (data_output_sof),
`endif
        .data_output_real    (data_output_real),
        .data_output_complex (data_output_complex)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter used to timestamp writes and outputs.
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Collector: record every valid output sample on the falling edge.
    always @(negedge clock) begin
        if (data_output_en === 1'b1) begin
            colRec.cyc = cycleCnt;
            colRec.re  = data_output_real;
            colRec.im  = data_output_complex;
`ifdef FFT_REORDER_SOF_EN
            colRec.sof = data_output_sof;
`else
            colRec.sof = 1'b0;
`endif
            outQ.push_back(colRec);
        end
`ifdef FFT_REORDER_SOF_EN
        if (data_output_sof === 1'b1 && data_output_en !== 1'b1) straySof++;
`endif
    end

    function automatic logic [5:0] tbRev6(input logic [5:0] k);
        return {k[0], k[1], k[2], k[3], k[4], k[5]};
    endfunction

    // Drive one valid sample on the next falling edge; it is written on the
    // following rising edge, whose cycleCnt value is remembered.
    task automatic applyStimulus(input logic [15:0] re);
        @(negedge clock);
        data_input_en      = 1'b1;
        data_input_real    = re;
        data_input_complex = ~re;
        lastWrite          = cycleCnt + 1;
    endtask

    task automatic driveIdle(input int n);
        repeat (n) begin
            @(negedge clock);
            data_input_en = 1'b0;
        end
    endtask

    task automatic driveFrame(input logic [15:0] offset, input bit gapped);
        logic [15:0] v;
        int          gaps;
        for (int k = 0; k < N; k++) begin
            if (gapped) begin
                gaps = 0;
                while (gaps < 16 && $urandom_range(0, 1) == 0) begin
                    driveIdle(1);
                    gaps++;
                end
            end
            v = {10'd0, tbRev6(6'(k))} + offset;
            applyStimulus(v);
        end
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        data_input_en      = 1'b0;
        data_input_real    = '0;
        data_input_complex = '0;
        repeat (3) @(negedge clock);
        testsRun++;
        if (data_output_en !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_en: got %b, expected 0", data_output_en);
        end
        testsRun++;
        if (data_output_real !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_real: got %h, expected 0000", data_output_real);
        end
        testsRun++;
        if (data_output_complex !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_imag: got %h, expected 0000", data_output_complex);
        end
`ifdef FFT_REORDER_SOF_EN
        testsRun++;
        if (data_output_sof !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_sof: got %b, expected 0", data_output_sof);
        end
`endif
        reset = 1'b0;
        outQ.delete();
        driveIdle(200);
        testsRun++;
        if (outQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_output: got %0d samples, expected 0", outQ.size());
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] expRe;
        outQ.delete();
        driveFrame(16'h0000, 1'b0);
        driveIdle(80);
        testsRun++;
        if (outQ.size() != N) begin
            testsFailed++;
            $display("[TB] FAIL single_count: got %0d samples, expected %0d", outQ.size(), N);
        end else begin
            testsRun++;
            if (outQ[0].cyc - lastWrite != 2) begin
                testsFailed++;
                $display("[TB] FAIL single_latency: got %0d cycles, expected 2", outQ[0].cyc - lastWrite);
            end
            for (int j = 0; j < N; j++) begin
                expRe = 16'(j);
                testsRun++;
                if (outQ[j].re !== expRe || outQ[j].im !== ~expRe || outQ[j].cyc != outQ[0].cyc + j) begin
                    testsFailed++;
                    $display("[TB] FAIL single_bin%0d: got re=%h im=%h cyc=%0d, expected re=%h im=%h cyc=%0d",
                             j, outQ[j].re, outQ[j].im, outQ[j].cyc, expRe, ~expRe, outQ[0].cyc + j);
                end
            end
        end
        testsRun++;
        if (data_output_real !== 16'd63 || data_output_complex !== ~16'd63) begin
            testsFailed++;
            $display("[TB] FAIL single_hold: got re=%h im=%h, expected re=%h im=%h",
                     data_output_real, data_output_complex, 16'd63, ~16'd63);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expRe;
        int          firstLast;
        outQ.delete();
        for (int f = 0; f < 4; f++) begin
            driveFrame(16'(256 * f), 1'b0);
            if (f == 0) firstLast = lastWrite;
        end
        driveIdle(80);
        testsRun++;
        if (outQ.size() != 4 * N) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: got %0d samples, expected %0d", outQ.size(), 4 * N);
        end else begin
            testsRun++;
            if (outQ[0].cyc - firstLast != 2) begin
                testsFailed++;
                $display("[TB] FAIL b2b_latency: got %0d cycles, expected 2", outQ[0].cyc - firstLast);
            end
            for (int j = 0; j < 4 * N; j++) begin
                expRe = 16'((j / N) * 256 + (j % N));
                testsRun++;
                if (outQ[j].re !== expRe || outQ[j].im !== ~expRe || outQ[j].cyc != outQ[0].cyc + j) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_sample%0d: got re=%h im=%h cyc=%0d, expected re=%h im=%h cyc=%0d",
                             j, outQ[j].re, outQ[j].im, outQ[j].cyc, expRe, ~expRe, outQ[0].cyc + j);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [15:0] expRe;
        int          burstStart;
        outQ.delete();
        driveFrame(16'h0000, 1'b1);
        driveFrame(16'h0000, 1'b1);
        driveIdle(80);
        testsRun++;
        if (outQ.size() != 2 * N) begin
            testsFailed++;
            $display("[TB] FAIL gaps_count: got %0d samples, expected %0d", outQ.size(), 2 * N);
        end else begin
            for (int j = 0; j < 2 * N; j++) begin
                expRe      = 16'(j % N);
                burstStart = outQ[(j / N) * N].cyc;
                testsRun++;
                if (outQ[j].re !== expRe || outQ[j].im !== ~expRe || outQ[j].cyc != burstStart + (j % N)) begin
                    testsFailed++;
                    $display("[TB] FAIL gaps_sample%0d: got re=%h im=%h cyc=%0d, expected re=%h im=%h cyc=%0d",
                             j, outQ[j].re, outQ[j].im, outQ[j].cyc, expRe, ~expRe, burstStart + (j % N));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] expRe;
        logic [15:0] v;
        outQ.delete();
        driveFrame(16'h0000, 1'b0);
        for (int k = 0; k < 30; k++) begin
            v = {10'd0, tbRev6(6'(k))} + 16'h0100;
            applyStimulus(v);
        end
        #2;
        testsRun++;
        if (data_output_en !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_active: got en=%b, expected 1", data_output_en);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (data_output_en !== 1'b0 || data_output_real !== 16'h0000 || data_output_complex !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL midreset_async: got en=%b re=%h im=%h, expected en=0 re=0000 im=0000",
                     data_output_en, data_output_real, data_output_complex);
        end
        driveIdle(3);
        reset = 1'b0;
        driveIdle(2);
        outQ.delete();
        driveFrame(16'h1000, 1'b0);
        driveIdle(80);
        testsRun++;
        if (outQ.size() != N) begin
            testsFailed++;
            $display("[TB] FAIL midreset_count: got %0d samples, expected %0d", outQ.size(), N);
        end else begin
            testsRun++;
            if (outQ[0].cyc - lastWrite != 2) begin
                testsFailed++;
                $display("[TB] FAIL midreset_latency: got %0d cycles, expected 2", outQ[0].cyc - lastWrite);
            end
            for (int j = 0; j < N; j++) begin
                expRe = 16'h1000 + 16'(j);
                testsRun++;
                if (outQ[j].re !== expRe || outQ[j].im !== ~expRe || outQ[j].cyc != outQ[0].cyc + j) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_bin%0d: got re=%h im=%h cyc=%0d, expected re=%h im=%h cyc=%0d",
                             j, outQ[j].re, outQ[j].im, outQ[j].cyc, expRe, ~expRe, outQ[0].cyc + j);
                end
            end
        end
    endtask

`ifdef FFT_REORDER_SOF_EN
    task automatic test_sof();
        int pulses;
        outQ.delete();
        straySof = 0;
        for (int f = 0; f < 4; f++) driveFrame(16'(256 * f), 1'b0);
        driveIdle(80);
        testsRun++;
        if (outQ.size() != 4 * N) begin
            testsFailed++;
            $display("[TB] FAIL sof_count: got %0d samples, expected %0d", outQ.size(), 4 * N);
        end else begin
            pulses = 0;
            for (int j = 0; j < 4 * N; j++) begin
                if (outQ[j].sof === 1'b1) pulses++;
                testsRun++;
                if (outQ[j].sof !== ((j % N) == 0)) begin
                    testsFailed++;
                    $display("[TB] FAIL sof_sample%0d: got %b, expected %b", j, outQ[j].sof, (j % N) == 0);
                end
            end
            testsRun++;
            if (pulses != 4) begin
                testsFailed++;
                $display("[TB] FAIL sof_pulses: got %0d, expected 4", pulses);
            end
        end
        testsRun++;
        if (straySof != 0) begin
            testsFailed++;
            $display("[TB] FAIL sof_stray: got %0d, expected 0", straySof);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
`ifdef FFT_REORDER_SOF_EN
        test_sof();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
